mem_io_unit: RTL and testbench



---
 rtl/mem_io_pkg.sv | 20 ++
 rtl/io_fifo.sv | 59 +++++
 rtl/mem_io_unit.sv | 135 +++++++++++++
 tb/tb_mem_io_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the memory / MMIO unit.
// I/O registers sit in the top four words of the address space.
package mem_io_pkg;

    localparam int TXD_OFS  = 4;
    localparam int STAT_OFS = 3;
    localparam int RXD_OFS  = 2;
    localparam int CTRL_OFS = 1;

    localparam int STAT_TX_FULL = 0;
    localparam int STAT_RX_FULL = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_MSB = 5;

    function automatic logic is_io(input logic [31:0] a, input int unsigned aw);
        return a >= ((32'd1 << aw) - 32'd4);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small circular FIFO with drop-on-full signalling.
// A push into a full FIFO is accepted only if a pop frees a slot the same cycle.
module io_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] buf_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = buf_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        drop     = push & full & ~do_pop;
        buf_d    = buf_q;
        if (do_push) begin
            buf_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_io_unit.sv
// Unified word RAM with registered read, plus TX FIFO / RX holding MMIO.
// dout is captured every cycle from the previous cycle's addr, read-first.
module mem_io_unit
    import mem_io_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int TX_DEPTH = 4,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we_mem,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int WORDS = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] A_TXD  = ADDR_W'(WORDS - TXD_OFS);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(WORDS - STAT_OFS);
    localparam logic [ADDR_W-1:0] A_RXD  = ADDR_W'(WORDS - RXD_OFS);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(WORDS - CTRL_OFS);

    logic [DATA_W-1:0] mem_q [WORDS];

    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
    logic              rx_full_q, rx_full_d;
    logic              ovf_q, ovf_d;

    logic              io_sel, ram_we;
    logic              wr_txd, wr_rxd, wr_ctrl;
    logic [DATA_W-1:0] rd_val, stat;
    logic [2:0]        cnt_sat;

    logic [DATA_W-1:0] tx_head;
    logic [CNT_W-1:0]  tx_cnt;
    logic              tx_full, tx_empty, tx_drop, tx_pop;

    assign tx_pop   = tx_valid & tx_ready;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_head;
    assign rx_ready = ~rx_full_q;
    assign dout     = dout_q;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txd),
        .push_data (din),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_cnt),
        .full      (tx_full),
        .empty     (tx_empty),
        .drop      (tx_drop)
    );

    always_comb begin
        io_sel  = is_io(32'(addr), ADDR_W);
        ram_we  = we_mem & ~io_sel & ~reset;
        wr_txd  = we_mem & (addr == A_TXD);
        wr_rxd  = we_mem & (addr == A_RXD);
        wr_ctrl = we_mem & (addr == A_CTRL);

        cnt_sat = (32'(tx_cnt) > 32'd7) ? 3'd7 : 3'(tx_cnt);
        stat = '0;
        stat[STAT_TX_FULL] = tx_full;
        stat[STAT_RX_FULL] = rx_full_q;
        stat[STAT_OVF]     = ovf_q;
        stat[STAT_CNT_MSB:STAT_CNT_LSB] = cnt_sat;

        if (addr == A_STAT) begin
            rd_val = stat;
        end else if (addr == A_RXD) begin
            rd_val = rx_hold_q;
        end else if (io_sel) begin
            rd_val = '0;
        end else begin
            rd_val = mem_q[addr];
        end
        dout_d = rd_val;

        rx_hold_d = rx_hold_q;
        rx_full_d = rx_full_q;
        if (rx_valid && !rx_full_q) begin
            rx_hold_d = rx_data;
            rx_full_d = 1'b1;
        end
        if (wr_rxd) begin
            rx_full_d = 1'b0;
        end

        // Set beats clear when both land in one cycle.
        ovf_d = ovf_q;
        if (wr_ctrl) begin
            ovf_d = 1'b0;
        end
        if (tx_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q    <= '0;
            rx_hold_q <= '0;
            rx_full_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            rx_hold_q <= rx_hold_d;
            rx_full_q <= rx_full_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mem_io_unit.sv
// Scoreboard bench for mem_io_unit: dout and TX expectations are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_mem_io_unit;

    localparam logic [7:0] TXD  = 8'hFC;
    localparam logic [7:0] STAT = 8'hFD;
    localparam logic [7:0] RXD  = 8'hFE;
    localparam logic [7:0] CTRL = 8'hFF;

    typedef struct {
        int          due;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic [15:0] din;
    logic        we_mem;
    logic [15:0] dout;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        dq[$];
    logic [15:0] tq[$];
    exp_t        me;
    logic [15:0] te;

    mem_io_unit dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .we_mem   (we_mem),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            me = dq.pop_front();
            total++;
            if (me.due != cyc || dout !== me.exp) begin
                bad++;
                $display("FAIL %s: dout=%h want=%h (cyc %0d due %0d)",
                         me.name, dout, me.exp, cyc, me.due);
            end
        end
        if (tx_valid && tx_ready) begin
            total++;
            if (tq.size() == 0) begin
                bad++;
                $display("FAIL tx_pop: unexpected word %h", tx_data);
            end else begin
                te = tq.pop_front();
                if (tx_data !== te) begin
                    bad++;
                    $display("FAIL tx_pop: tx_data=%h want=%h", tx_data, te);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr   = a;
        din    = d;
        we_mem = 1'b1;
        tick();
        we_mem = 1'b0;
    endtask

    task automatic txw(input logic [15:0] d);
        tq.push_back(d);
        wr(TXD, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e,
                      input string n);
        addr   = a;
        we_mem = 1'b0;
        dq.push_back('{due: cyc + 1, exp: e, name: n});
        tick();
    endtask

    task automatic drain(input string n);
        tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!tx_valid) break;
        end
        tx_ready = 1'b0;
        chk({n, "_valid"}, 32'(tx_valid), 32'd0);
        chk({n, "_left"}, 32'(tq.size()), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        addr     = 8'h10;
        din      = '0;
        we_mem   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        dq.push_back('{due: cyc + 1, exp: 16'h0, name: "reset_dout"});
        tick();
        reset = 1'b0;
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_rx_ready", 32'(rx_ready), 32'd1);
        rd(STAT, 16'h0000, "reset_stat");

        wr(8'h10, 16'h1234);
        rd(8'h10, 16'h1234, "ram_hold1");
        rd(8'h10, 16'h1234, "ram_hold2");
        wr(8'hFB, 16'h5A5A);
        rd(8'hFB, 16'h5A5A, "ram_top");
        rd(TXD, 16'h0000, "txd_read");
        rd(CTRL, 16'h0000, "ctrl_read");

        txw(16'h00A1);
        txw(16'h00A2);
        txw(16'h00A3);
        txw(16'h00A4);
        rd(STAT, 16'h0021, "stat_full4");
        chk("tx_head", 32'(tx_data), 32'h00A1);
        chk("tx_valid_full", 32'(tx_valid), 32'd1);
        drain("drain_a");

        txw(16'h00C1);
        txw(16'h00C2);
        txw(16'h00C3);
        txw(16'h00C4);
        wr(TXD, 16'h00FF);
        rd(STAT, 16'h0025, "stat_ovf");
        wr(CTRL, 16'h0000);
        rd(STAT, 16'h0021, "stat_ovf_clr");
        wr(STAT, 16'hFFFF);
        rd(STAT, 16'h0021, "stat_ro");
        tx_ready = 1'b1;
        txw(16'h00B0);
        tx_ready = 1'b0;
        rd(STAT, 16'h0021, "stat_pushpop");
        drain("drain_b");

        rx_data  = 16'h0042;
        rx_valid = 1'b1;
        tick();
        chk("rx_ready_low", 32'(rx_ready), 32'd0);
        rx_data = 16'h0043;
        rd(STAT, 16'h0002, "stat_rx");
        rd(RXD, 16'h0042, "rxd_first");
        rd(RXD, 16'h0042, "rxd_held");
        wr(RXD, 16'h0000);
        chk("rx_ready_ack", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        chk("rx_ready_again", 32'(rx_ready), 32'd0);
        rd(RXD, 16'h0043, "rxd_second");
        wr(RXD, 16'h0000);

        wr(8'h20, 16'h1111);
        addr   = 8'h20;
        din    = 16'h2222;
        we_mem = 1'b1;
        dq.push_back('{due: cyc + 1, exp: 16'h1111, name: "rdw_old"});
        tick();
        we_mem = 1'b0;
        rd(8'h20, 16'h2222, "rdw_new");

        txw(16'h00D1);
        txw(16'h00D2);
        txw(16'h00D3);
        txw(16'h00D4);
        wr(TXD, 16'h00EE);
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        rx_data  = 16'h0055;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd(STAT, 16'h0016, "stat_pre_reset");

        reset  = 1'b1;
        addr   = 8'h10;
        din    = 16'hDEAD;
        we_mem = 1'b1;
        dq.push_back('{due: cyc + 1, exp: 16'h0, name: "rst_dout"});
        tick();
        reset  = 1'b0;
        we_mem = 1'b0;
        tq.delete();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        rd(STAT, 16'h0000, "rst_stat");
        rd(8'h10, 16'h1234, "rst_ram");
        tick();
        tick();
        chk("dout_queue_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end

endmodule
